mem_arbiter: RTL and testbench

Sequences a single-ported unified memory shared by the instruction-fetch path and the load/store path of the core. Each requester gets a request/grant/response handshake. The arbiter picks a winner, forwards one transaction to memory, and tracks it until the response. It then routes the response back to the owner. At most one transaction is outstanding at any time.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_fair_ctr.sv | 49 ++++
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory arbiter.
// Holds the FSM state and owner enums plus default width constants.
package mem_arb_pkg;

    localparam int unsigned ARB_ADDR_W  = 32;
    localparam int unsigned ARB_DATA_W  = 32;
    localparam int unsigned ARB_MAX_RUN = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_WAIT
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_e;

endpackage

// File: rtl/mem_arb_fair_ctr.sv
// Saturating count of data grants taken while fetch was waiting.
// Ports: clk, rst_n, if_req, if_gnt, d_gnt in; fetch_boost out.
module mem_arb_fair_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DATA_RUN = ARB_MAX_RUN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic if_req,
    input  logic if_gnt,
    input  logic d_gnt,
    output logic fetch_boost
);

    localparam int unsigned CW = $clog2(MAX_DATA_RUN + 1);

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t CNT_MAX = cnt_t'(MAX_DATA_RUN);

    cnt_t cnt_q;
    cnt_t cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (if_gnt) begin
            cnt_d = '0;
        end else if (d_gnt) begin
            if (!if_req) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fetch overrides data only while it is actually asking.
    assign fetch_boost = if_req & (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and load/store.
// Ports: if_* fetch side, d_* data side, m_* memory side; clk, rst_n.
// Define MEM_ARB_FAIR_EN to bound data runs while fetch waits.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = ARB_ADDR_W,
    parameter int unsigned DATA_WIDTH   = ARB_DATA_W,
    parameter int unsigned MAX_DATA_RUN = ARB_MAX_RUN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    if (MAX_DATA_RUN < 1) begin : g_bad_run
        $error("MAX_DATA_RUN must be at least 1");
    end

    arb_state_e state_q;
    arb_state_e state_d;
    arb_owner_e owner_q;
    arb_owner_e owner_d;

    logic fetch_boost;
    logic d_win;
    logic if_win;

`ifdef MEM_ARB_FAIR_EN
    mem_arb_fair_ctr #(
        .MAX_DATA_RUN(MAX_DATA_RUN)
    ) u_fair_ctr (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_gnt     (if_gnt),
        .d_gnt      (d_gnt),
        .fetch_boost(fetch_boost)
    );
`else
    assign fetch_boost = 1'b0;
`endif

    // Data is the older instruction, so it wins unless fetch is boosted.
    assign d_win  = d_req & ~fetch_boost;
    assign if_win = if_req & (~d_req | fetch_boost);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            owner_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        unique case (state_q)
            ARB_IDLE: begin
                if ((if_req | d_req) & m_ready) begin
                    state_d = ARB_WAIT;
                    owner_d = d_win ? OWN_D : OWN_IF;
                end
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    state_d = ARB_IDLE;
                    owner_d = OWN_NONE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // Everything is forced low while reset is held, including the
    // combinational request path and the read-data mirrors.
    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
        if (rst_n) begin
            unique case (state_q)
                ARB_IDLE: begin
                    m_req = if_req | d_req;
                    if (d_win) begin
                        m_we    = d_we;
                        m_addr  = d_addr;
                        m_wdata = d_wdata;
                    end else if (if_win) begin
                        m_addr  = if_addr;
                    end
                    if_gnt = if_win & m_ready;
                    d_gnt  = d_win & m_ready;
                end
                ARB_WAIT: begin
                    if_rvalid = m_rvalid & (owner_q == OWN_IF);
                    d_rvalid  = m_rvalid & (owner_q == OWN_D);
                end
                default: begin
                    m_req = 1'b0;
                end
            endcase
        end
    end

    assign if_rdata = rst_n ? m_rdata : '0;
    assign d_rdata  = rst_n ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected grants are queued as
// stimulus is set up and retired as the arbiter grants/responds.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;

    mem_arbiter u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_errors;

    int          if_left;
    int          if_idx;
    logic [31:0] if_base;
    int          d_left;
    int          d_idx;
    logic [31:0] d_base;
    logic        d_we_c;
    logic [31:0] d_wdata_c;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_reqs();
        if_req  = (if_left > 0);
        if_addr = if_base + 32'(if_idx * 4);
        d_req   = (d_left > 0);
        d_we    = d_we_c;
        d_addr  = d_base + 32'(d_idx * 4);
        d_wdata = d_wdata_c + 32'(d_idx);
    endtask

    task automatic push_if(input int idx, input logic [31:0] rd);
        exp_t e;
        e.is_d  = 1'b0;
        e.we    = 1'b0;
        e.addr  = if_base + 32'(idx * 4);
        e.wdata = '0;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic push_d(input int idx, input logic [31:0] rd);
        exp_t e;
        e.is_d  = 1'b1;
        e.we    = d_we_c;
        e.addr  = d_base + 32'(idx * 4);
        e.wdata = d_wdata_c + 32'(idx);
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    task automatic setup(input int il, input logic [31:0] ib,
                         input int dl, input logic [31:0] db,
                         input logic we, input logic [31:0] wd);
        if_left   = il;
        if_idx    = 0;
        if_base   = ib;
        d_left    = dl;
        d_idx     = 0;
        d_base    = db;
        d_we_c    = we;
        d_wdata_c = wd;
    endtask

    // hold: cycles of m_ready low before each grant
    // lat : cycles from grant to m_rvalid (>= 1)
    task automatic serve(input int n, input int hold, input int lat);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            if (exp_q.size() == 0) begin
                chk("sb_empty", 64'(1), 64'(0));
                return;
            end
            e = exp_q.pop_front();
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                drive_reqs();
                m_ready  = 1'b0;
                m_rvalid = 1'b0;
                #1;
                chk("bp_mreq", 64'(m_req), 64'(1));
                chk("bp_gnt", 64'({if_gnt, d_gnt}), 64'(0));
            end
            @(negedge clk);
            drive_reqs();
            m_ready  = 1'b1;
            m_rvalid = 1'b0;
            #1;
            chk("gnt", 64'({if_gnt, d_gnt}), e.is_d ? 64'(1) : 64'(2));
            chk("m_req", 64'(m_req), 64'(1));
            chk("m_addr", 64'(m_addr), 64'(e.addr));
            chk("m_we", 64'(m_we), 64'(e.we));
            if (e.is_d && e.we) begin
                chk("m_wdata", 64'(m_wdata), 64'(e.wdata));
            end
            if (e.is_d) begin
                d_left--;
                d_idx++;
            end else begin
                if_left--;
                if_idx++;
            end
            for (int w = 1; w < lat; w++) begin
                @(negedge clk);
                drive_reqs();
                m_rvalid = 1'b0;
                #1;
                chk("wait_ctl",
                    64'({m_req, if_gnt, d_gnt, if_rvalid, d_rvalid}),
                    64'(0));
            end
            @(negedge clk);
            drive_reqs();
            m_rvalid = 1'b1;
            m_rdata  = e.rdata;
            #1;
            chk("rvalid", 64'({if_rvalid, d_rvalid}),
                e.is_d ? 64'(1) : 64'(2));
            chk("rdata", 64'(e.is_d ? d_rdata : if_rdata), 64'(e.rdata));
            chk("rv_gnt", 64'({if_gnt, d_gnt}), 64'(0));
        end
        @(negedge clk);
        drive_reqs();
        m_rvalid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"},
            64'({if_gnt, if_rvalid, d_gnt, d_rvalid, m_req, m_we}),
            64'(0));
        chk({tag, "_rdata"}, {if_rdata, d_rdata}, 64'(0));
        chk({tag, "_mbus"}, {m_addr, m_wdata}, 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h0000_0AA0;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_addr   = 32'h0000_0BB0;
        d_wdata  = 32'h1234_5678;
        m_ready  = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'hA5A5_5A5A;
        #1;
        check_all_zero("rst");
        @(negedge clk);
        setup(0, 32'h0, 0, 32'h0, 1'b0, 32'h0);
        drive_reqs();
        m_rvalid = 1'b0;
        m_ready  = 1'b0;
        m_rdata  = '0;
        rst_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        setup(0, 32'h0, 0, 32'h0, 1'b0, 32'h0);
        drive_reqs();
        m_ready  = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
        do_reset();

        // fetch only
        setup(1, 32'h100, 0, 32'h0, 1'b0, 32'h0);
        push_if(0, 32'hDEAD_BEEF);
        serve(1, 0, 1);

        // both in same cycle: store first, fetch right after
        setup(1, 32'h104, 1, 32'h2000, 1'b1, 32'h55);
        push_d(0, $urandom);
        push_if(0, $urandom);
        serve(2, 0, 1);

        // memory backpressure on a load
        setup(0, 32'h0, 1, 32'h3000, 1'b0, 32'h77);
        push_d(0, $urandom);
        serve(1, 3, 1);

        // late responses, both requesters
        setup(1, 32'h400, 1, 32'h4000, 1'b0, 32'h0);
        push_d(0, $urandom);
        push_if(0, $urandom);
        serve(2, 0, 6);

        // stray response while idle is dropped
        @(negedge clk);
        m_rvalid = 1'b1;
        m_rdata  = 32'hCAFE_F00D;
        #1;
        chk("idle_rv", 64'({if_rvalid, d_rvalid, m_req}), 64'(0));
        @(negedge clk);
        m_rvalid = 1'b0;

        // reset in the middle of a fetch
        setup(1, 32'h300, 0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        drive_reqs();
        m_ready = 1'b1;
        #1;
        chk("rw_gnt", 64'({if_gnt, d_gnt}), 64'(2));
        if_left = 0;
        @(negedge clk);
        drive_reqs();
        #1;
        chk("rw_wait", 64'(m_req), 64'(0));
        @(negedge clk);
        rst_n    = 1'b0;
        if_req   = 1'b1;
        d_req    = 1'b1;
        m_rvalid = 1'b1;
        m_rdata  = 32'h1111_2222;
        #1;
        check_all_zero("rw_rst");
        @(negedge clk);
        rst_n  = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        chk("rw_late", 64'({if_rvalid, d_rvalid}), 64'(0));
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        chk("rw_idle", 64'({if_rvalid, d_rvalid, m_req}), 64'(0));

        // arbiter recovers after the abandoned transaction
        setup(1, 32'h500, 0, 32'h0, 1'b0, 32'h0);
        push_if(0, $urandom);
        serve(1, 0, 2);

        // continuous contention from a clean counter
        do_reset();
        setup(2, 32'h600, 6, 32'h6000, 1'b0, 32'h0);
`ifdef MEM_ARB_FAIR_EN
        for (int i = 0; i < 4; i++) push_d(i, $urandom);
        push_if(0, $urandom);
        for (int i = 4; i < 6; i++) push_d(i, $urandom);
        push_if(1, $urandom);
`else
        for (int i = 0; i < 6; i++) push_d(i, $urandom);
        push_if(0, $urandom);
        push_if(1, $urandom);
`endif
        serve(8, 0, 1);
        chk("sb_drain", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
